// File: rtl/adc_pkt_framer.sv
// Snapshots a wide multi-lane ADC word and emits it as a framed packet
// on a 36-bit valid/ready stream: header, len data beats, XOR trailer.
module adc_pkt_framer #(
    parameter int NUM_LANES = 24,
    parameter int LANE_W    = 36,
    parameter int FRM_W     = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        cfg_en,
    input  logic [7:0]                  cfg_len,
    input  logic [FRM_W-1:0]            cfg_frames,
    input  logic                        start,
    input  logic [NUM_LANES*LANE_W-1:0] in_data,
    input  logic                        in_valid,
    output logic [LANE_W-1:0]           out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_sop,
    output logic                        out_eop,
    output logic                        busy,
    output logic                        done,
    output logic [FRM_W-1:0]            drop_cnt,
    output logic [7:0]                  seq
);

    localparam int         IW  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [7:0] NL8 = 8'(NUM_LANES);

    typedef enum logic [2:0] {IDLE, WAIT, HDR, DATA, TAIL} state_t;

    state_t             state_q, state_d;
    logic [7:0]         len_q, len_d;
    logic [FRM_W-1:0]   frames_q, frames_d;
    logic               cont_q, cont_d;
    logic [7:0]         seq_q, seq_d;
    logic [FRM_W-1:0]   drop_q, drop_d;
    logic [LANE_W-1:0]  chk_q, chk_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [LANE_W-1:0]  od_q, od_d;
    logic               ov_q, ov_d;
    logic               sop_q, sop_d;
    logic               eop_q, eop_d;
    logic               done_q, done_d;
    logic [LANE_W-1:0]  shadow_q [NUM_LANES];
    logic               snap;
    logic               xfer;
    logic               last;
    logic [7:0]         len_eff;
    logic [LANE_W-1:0]  chk_nx;

    assign xfer    = ov_q & out_ready;
    assign last    = (8'(idx_q) == len_q - 8'd1);
    assign len_eff = (cfg_len == 8'd0 || cfg_len > NL8) ? NL8 : cfg_len;
    assign chk_nx  = chk_q ^ od_q;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        frames_d = frames_q;
        cont_d   = cont_q;
        seq_d    = seq_q;
        drop_d   = drop_q;
        chk_d    = chk_q;
        idx_d    = idx_q;
        od_d     = od_q;
        ov_d     = ov_q;
        sop_d    = sop_q;
        eop_d    = eop_q;
        done_d   = 1'b0;
        snap     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && cfg_en) begin
                    len_d    = len_eff;
                    frames_d = cfg_frames;
                    cont_d   = (cfg_frames == '0);
                    seq_d    = 8'd0;
                    drop_d   = '0;
                    chk_d    = '0;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (!cfg_en) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (in_valid) begin
                    snap    = 1'b1;
                    chk_d   = '0;
                    ov_d    = 1'b1;
                    sop_d   = 1'b1;
                    od_d    = LANE_W'({4'hA, seq_q, len_q, 16'h0000});
                    state_d = HDR;
                end
            end
            HDR: begin
                if (xfer) begin
                    idx_d   = '0;
                    sop_d   = 1'b0;
                    od_d    = shadow_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (xfer) begin
                    chk_d = chk_nx;
                    if (last) begin
                        eop_d   = 1'b1;
                        od_d    = chk_nx;
                        state_d = TAIL;
                    end else begin
                        idx_d = idx_q + IW'(1);
                        od_d  = shadow_q[idx_q + IW'(1)];
                    end
                end
            end
            TAIL: begin
                if (xfer) begin
                    ov_d  = 1'b0;
                    eop_d = 1'b0;
                    od_d  = '0;
                    seq_d = seq_q + 8'd1;
                    if (!cont_q) frames_d = frames_q - FRM_W'(1);
                    if ((!cont_q && frames_q == FRM_W'(1)) || !cfg_en) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Any snapshot offered while a packet is in flight is lost.
        if (in_valid && (state_q == HDR || state_q == DATA || state_q == TAIL)
            && drop_q != {FRM_W{1'b1}})
            drop_d = drop_q + FRM_W'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            len_q    <= '0;
            frames_q <= '0;
            cont_q   <= 1'b0;
            seq_q    <= '0;
            drop_q   <= '0;
            chk_q    <= '0;
            idx_q    <= '0;
            od_q     <= '0;
            ov_q     <= 1'b0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            frames_q <= frames_d;
            cont_q   <= cont_d;
            seq_q    <= seq_d;
            drop_q   <= drop_d;
            chk_q    <= chk_d;
            idx_q    <= idx_d;
            od_q     <= od_d;
            ov_q     <= ov_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (snap) begin
            for (int k = 0; k < NUM_LANES; k++)
                if (k < int'(len_q)) shadow_q[k] <= in_data[k*LANE_W +: LANE_W];
        end
    end

    assign out_data  = od_q;
    assign out_valid = ov_q;
    assign out_sop   = sop_q;
    assign out_eop   = eop_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign drop_cnt  = drop_q;
    assign seq       = seq_q;

endmodule
